// File: rtl/uart_rx_frame.sv
// UART receive framer: configurable data/parity/stop bits, 3-sample majority vote,
// parity/framing/break/overrun flags and a valid/ready word handshake.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 UART_RXD,
  input  logic                 RX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_DONE,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_BREAK,
  output logic                 RX_OVERRUN
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(H);
  localparam logic [CW-1:0] CNT_HP1  = CW'(H + 1);
  localparam logic [IW-1:0] IDX_LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST_S = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR    = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  state_e                 state_r, state_n;
  logic                   sync1_r, rxs_r;
  logic [CW-1:0]          cnt_r, cnt_n;
  logic [IW-1:0]          idx_r, idx_n;
  logic [1:0]             samp_r, samp_n;
  logic [DATA_BITS-1:0]   shift_r, shift_n;
  logic                   par_bit_r, par_bit_n;
  logic                   stop_err_r, stop_err_n;
  logic [DATA_BITS-1:0]   data_n;
  logic                   valid_n, done_n, perr_n, ferr_n, brk_n, ovr_n;
  logic                   vote_s, decide_s, last_s, complete_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign vote_s   = maj3(samp_r[0], samp_r[1], rxs_r);
  assign decide_s = (cnt_r == CNT_HP1);
  assign last_s   = (cnt_r == CNT_LAST);

  // Next-state, sampling and output-update logic.
  always_comb begin
    state_n    = state_r;
    cnt_n      = (state_r == IDLE || last_s) ? {CW{1'b0}} : cnt_r + CW'(1);
    idx_n      = idx_r;
    samp_n     = samp_r;
    shift_n    = shift_r;
    par_bit_n  = par_bit_r;
    stop_err_n = stop_err_r;
    complete_s = 1'b0;
    data_n     = RX_DATA;
    valid_n    = RX_VALID;
    done_n     = 1'b0;
    perr_n     = RX_PARITY_ERR;
    ferr_n     = RX_FRAME_ERR;
    brk_n      = RX_BREAK;
    ovr_n      = RX_OVERRUN;

    if (cnt_r == CNT_HM1) begin
      samp_n[0] = rxs_r;
    end else if (cnt_r == CNT_H) begin
      samp_n[1] = rxs_r;
    end else begin
      samp_n = samp_r;
    end

    case (state_r)
      IDLE: begin
        if (!rxs_r) begin
          state_n    = START;
          idx_n      = {IW{1'b0}};
          stop_err_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (decide_s && vote_s) begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
        end else if (last_s) begin
          state_n = DATA;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (decide_s) begin
          shift_n[idx_r] = vote_s;
        end else begin
          shift_n = shift_r;
        end
        if (last_s) begin
          if (idx_r == IDX_LAST_D) begin
            idx_n   = {IW{1'b0}};
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_n = idx_r + IW'(1);
          end
        end else begin
          idx_n = idx_r;
        end
      end
      PAR: begin
        if (decide_s) begin
          par_bit_n = vote_s;
        end else begin
          par_bit_n = par_bit_r;
        end
        if (last_s) begin
          state_n = STOP;
        end else begin
          state_n = PAR;
        end
      end
      STOP: begin
        if (decide_s) begin
          stop_err_n = stop_err_r | ~vote_s;
          if (idx_r == IDX_LAST_S) begin
            complete_s = 1'b1;
            cnt_n      = {CW{1'b0}};
            state_n    = vote_s ? IDLE : WAIT_HIGH;
          end else begin
            state_n = STOP;
          end
        end else if (last_s) begin
          idx_n = idx_r + IW'(1);
        end else begin
          state_n = STOP;
        end
      end
      WAIT_HIGH: begin
        if (rxs_r) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_HIGH;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CW{1'b0}};
        idx_n   = {IW{1'b0}};
      end
    endcase

    // A completing frame wins over a plain acceptance; the new word replaces the old.
    if (complete_s) begin
      data_n  = shift_r;
      done_n  = 1'b1;
      valid_n = 1'b1;
      ferr_n  = stop_err_r | ~vote_s;
      brk_n   = ~(|shift_r) & ~par_bit_r & ~vote_s;
      if (PARITY != 0) begin
        perr_n = (^{shift_r, par_bit_r}) != ODD_PAR;
      end else begin
        perr_n = 1'b0;
      end
      if (RX_VALID && !RX_READY) begin
        ovr_n = 1'b1;
      end else if (RX_VALID && RX_READY) begin
        ovr_n = 1'b0;
      end else begin
        ovr_n = RX_OVERRUN;
      end
    end else if (RX_VALID && RX_READY) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end else begin
      valid_n = RX_VALID;
    end
  end

  // Synchroniser, framer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r       <= 1'b1;
      rxs_r         <= 1'b1;
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      idx_r         <= {IW{1'b0}};
      samp_r        <= 2'b11;
      shift_r       <= {DATA_BITS{1'b0}};
      par_bit_r     <= 1'b0;
      stop_err_r    <= 1'b0;
      RX_DATA       <= {DATA_BITS{1'b0}};
      RX_VALID      <= 1'b0;
      RX_DONE       <= 1'b0;
      RX_PARITY_ERR <= 1'b0;
      RX_FRAME_ERR  <= 1'b0;
      RX_BREAK      <= 1'b0;
      RX_OVERRUN    <= 1'b0;
    end else begin
      sync1_r       <= UART_RXD;
      rxs_r         <= sync1_r;
      state_r       <= state_n;
      cnt_r         <= cnt_n;
      idx_r         <= idx_n;
      samp_r        <= samp_n;
      shift_r       <= shift_n;
      par_bit_r     <= par_bit_n;
      stop_err_r    <= stop_err_n;
      RX_DATA       <= data_n;
      RX_VALID      <= valid_n;
      RX_DONE       <= done_n;
      RX_PARITY_ERR <= perr_n;
      RX_FRAME_ERR  <= ferr_n;
      RX_BREAK      <= brk_n;
      RX_OVERRUN    <= ovr_n;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and a 7E2 instance, both at 16 clk/bit.
module tb_uart_rx_frame;
  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1, rxd_b = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic valid_a, done_a, perr_a, ferr_a, brk_a, ovr_a;
  logic valid_b, done_b, perr_b, ferr_b, brk_b, ovr_b;

  int cyc = 0, t0 = 0;
  int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
  int n_checks = 0, n_fail = 0;
  int base;

  uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .UART_RXD(rxd_a), .RX_READY(ready_a),
    .RX_DATA(data_a), .RX_VALID(valid_a), .RX_DONE(done_a), .RX_PARITY_ERR(perr_a),
    .RX_FRAME_ERR(ferr_a), .RX_BREAK(brk_a), .RX_OVERRUN(ovr_a));

  uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .UART_RXD(rxd_b), .RX_READY(ready_b),
    .RX_DATA(data_b), .RX_VALID(valid_b), .RX_DONE(done_b), .RX_PARITY_ERR(perr_b),
    .RX_FRAME_ERR(ferr_b), .RX_BREAK(brk_b), .RX_OVERRUN(ovr_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses and record the edge index at which each one appeared.
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      done_cyc_b <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else rxd_a = v;
  endtask

  // Sends n line bits LSB first; with glitch set, bits 1..8 get a one-cycle inversion mid-bit.
  task automatic send_bits(input bit sel, input logic [23:0] bits, input int n, input bit glitch);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) t0 = cyc + 1;
      drive(sel, bits[k]);
      if (glitch && k >= 1 && k <= 8) begin
        repeat (9) @(posedge clk);
        #1 drive(sel, ~bits[k]);
        @(posedge clk);
        #1 drive(sel, bits[k]);
        repeat (C - 11) @(posedge clk);
      end else begin
        repeat (C - 1) @(posedge clk);
      end
    end
  endtask

  task automatic accept_a();
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {data_a, valid_a, done_a, perr_a, ferr_a, brk_a, ovr_a}, 32'h0);
    check("reset_outputs_b", {data_b, valid_b, done_b, perr_b, ferr_b, brk_b, ovr_b}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 8N1 0xA5
    send_bits(1'b0, {1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    check("a5_done_time", 32'(done_cyc_a - t0), 32'd156);
    check("a5_done_cnt", 32'(done_cnt_a), 32'd1);
    check("a5_data", {24'h0, data_a}, 32'h0000_00A5);
    check("a5_valid", {31'h0, valid_a}, 32'h1);
    check("a5_flags", {28'h0, perr_a, ferr_a, brk_a, ovr_a}, 32'h0);
    accept_a();
    check("a5_accept_valid", {31'h0, valid_a}, 32'h0);

    // 7E2 0x41, parity bit 1 (wrong), then 0 (right)
    send_bits(1'b1, {2'b11, 1'b1, 7'h41, 1'b0}, 11, 1'b0);
    check("par1_done_time", 32'(done_cyc_b - t0), 32'd172);
    check("par1_perr", {31'h0, perr_b}, 32'h1);
    check("par1_data", {25'h0, data_b}, 32'h0000_0041);
    check("par1_ferr", {31'h0, ferr_b}, 32'h0);
    send_bits(1'b1, {2'b11, 1'b0, 7'h41, 1'b0}, 11, 1'b0);
    check("par0_perr", {31'h0, perr_b}, 32'h0);
    check("par0_data", {25'h0, data_b}, 32'h0000_0041);
    check("par0_overrun", {31'h0, ovr_b}, 32'h1);
    // First stop bit low, second high: framing error but not a break
    send_bits(1'b1, {2'b10, 1'b0, 7'h00, 1'b0}, 11, 1'b0);
    check("stop1_flags", {29'h0, perr_b, ferr_b, brk_b}, 32'h2);
    check("stop1_done_cnt", 32'(done_cnt_b), 32'd3);

    // Break: all zero including stop, line then held low
    base = done_cnt_a;
    send_bits(1'b0, {1'b0, 8'h00, 1'b0}, 10, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("brk_flags", {29'h0, ferr_a, brk_a, perr_a}, 32'h6);
    check("brk_data", {24'h0, data_a}, 32'h0);
    check("brk_state_wait", 32'(dut_a.state_r), 32'd5);
    rxd_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("brk_state_idle", 32'(dut_a.state_r), 32'd0);
    check("brk_done_cnt", 32'(done_cnt_a - base), 32'd1);
    accept_a();

    // Back-to-back 0x12, 0x34 without acceptance
    base = done_cnt_a;
    send_bits(1'b0, {1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}, 20, 1'b0);
    check("b2b_done_cnt", 32'(done_cnt_a - base), 32'd2);
    check("b2b_overrun", {31'h0, ovr_a}, 32'h1);
    check("b2b_data", {24'h0, data_a}, 32'h0000_0034);
    accept_a();
    check("b2b_accept", {30'h0, valid_a, ovr_a}, 32'h0);

    // 3-cycle low glitch is rejected
    base = done_cnt_a;
    @(posedge clk); #1 rxd_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_done", 32'(done_cnt_a - base), 32'd0);
    check("glitch_idle", 32'(dut_a.state_r), 32'd0);
    // Single-sample glitches inside every data bit are outvoted
    send_bits(1'b0, {1'b1, 8'h3C, 1'b0}, 10, 1'b1);
    check("glitch_byte", {24'h0, data_a}, 32'h0000_003C);
    check("glitch_byte_flags", {29'h0, perr_a, ferr_a, brk_a}, 32'h0);
    check("glitch_byte_done", 32'(done_cnt_a - base), 32'd1);

    // Reset during data bit 4 of 0x5A
    base = done_cnt_a;
    send_bits(1'b0, {4'hA, 1'b0}, 5, 1'b0);
    @(posedge clk); #1 rxd_a = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", {data_a, valid_a, done_a, perr_a, ferr_a, brk_a, ovr_a}, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (C * 12) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt_a - base), 32'd0);
    send_bits(1'b0, {1'b1, 8'h5A, 1'b0}, 10, 1'b0);
    check("rst_next_data", {24'h0, data_a}, 32'h0000_005A);
    check("rst_next_done", 32'(done_cnt_a - base), 32'd1);
    check("rst_next_time", 32'(done_cyc_a - t0), 32'd156);
    check("rst_next_valid", {30'h0, valid_a, ovr_a}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive framer for the I/O subsystem, next generation of the fixed 8N1 receiver. It adds configurable data width, parity, and stop bits. Bit decisions use a double-flop input synchroniser and 3-sample majority vote. It flags parity, framing, break and overrun errors, and presents each received word through a valid/ready handshake to the memory-mapped UART register block.

## Interface
- CLKS_PER_BIT, 5208, clk cycles per bit (C); legal ≥ 8; H = C/2 (integer divide)
- DATA_BITS, 8, data bits per frame (D); legal 5..9
- PARITY, 0, 0 none, 1 odd, 2 even; P = 1 if PARITY≠0, else 0
- STOP_BITS, 1, stop bits (S); legal 1 or 2

- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- UART_RXD  input  1  serial line, asynchronous, idle high
- RX_READY  input  1  consumer accepts the word when RX_VALID & RX_READY at a clk edge
- RX_DATA  output  D  received word, LSB first on the line
- RX_VALID  output  1  word pending; held until accepted
- RX_DONE  output  1  one-cycle pulse per completed frame (good or bad)
- RX_PARITY_ERR  output  1  parity mismatch on last frame; 0 when PARITY=0
- RX_FRAME_ERR  output  1  a stop bit voted 0 on last frame
- RX_BREAK  output  1  last frame all-zero: data, parity, and stop bits
- RX_OVERRUN  output  1  sticky: a frame completed while RX_VALID=1 and not being accepted

## Operation
- Synchroniser: two flops, reset to 1; all logic uses the second flop (rxs).
- Bit counter: $clog2(C) bits, 0..C-1; counter 0 marks each bit start. Samples of rxs are taken when counter = H-1, H, H+1. The bit value is the majority of these 3 samples, decided at counter = H+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START with counter=0, bit index=0.
  - START: vote=1 → IDLE (glitch, no RX_DONE). Else, at counter C-1 → DATA.
  - DATA: shift vote into bit [index] at the decision. At C-1, index+1; after D bits → PARITY if P=1, else STOP.
  - PARITY: capture vote; at C-1 → STOP.
  - STOP: check vote=1 per stop bit. On the last stop bit's decision, complete the frame (below), then go to IDLE if vote=1, else WAIT_HIGH. No wait for the end of the stop bit, so back-to-back frames are supported.
  - WAIT_HIGH: stay until rxs=1, then IDLE.
- Frame completion, single clk edge:
  - RX_DATA ← shift reg; RX_DONE ← 1 for one cycle.
  - RX_PARITY_ERR ← (XOR of data ^ parity bit) ≠ (PARITY==1). Odd parity requires odd total ones.
  - RX_FRAME_ERR ← any stop vote = 0.
  - RX_BREAK ← data=0 & parity bit (if any)=0 & last stop vote=0.
  - RX_VALID ← 1.
  - If RX_VALID=1 and RX_READY=0 at the same edge, RX_OVERRUN ← 1 and the old word is overwritten.
- Handshake: RX_VALID & RX_READY with no completion that cycle → RX_VALID ← 0, RX_OVERRUN ← 0. Acceptance and completion in the same cycle → new word loaded, RX_VALID stays 1, no overrun.
- Error flags update only at completion and hold until the next completion.
- Reset (async, any state, mid-frame included):
  - State IDLE; counter and index 0; synchroniser 1.
  - RX_DATA=0; RX_VALID, RX_DONE, RX_PARITY_ERR, RX_FRAME_ERR, RX_BREAK, RX_OVERRUN = 0.
  - A frame interrupted by reset produces no RX_DONE.

## Timing
- t0 = first clk edge at which the synchroniser's first flop captures UART_RXD=0.
- START is entered at edge t0+2 with counter 0.
- Bit k (k=0 start bit) has counter 0 from edge t0+2+k·C.
- N = D+P+S, the index of the last stop bit.
- RX_DONE and the new RX_VALID/flags rise at edge t0+N·C+H+4; RX_DONE falls 1 cycle later.
- Earliest next start detect: the edge after completion.
- Glitch rejection: a low pulse shorter than 2 samples spanning H-1..H+1 returns to IDLE at edge t0+H+4.
- RX_READY → RX_VALID deassert latency: same edge.

## Test plan
- C=16, 8N1, send 0xA5 → RX_DONE at t0+156; RX_DATA=0xA5; RX_VALID=1; all error flags 0.
- PARITY=2, D=7, send 0x41 with parity bit 1 → RX_PARITY_ERR=1. Repeat with parity bit 0 → RX_PARITY_ERR=0, RX_DATA=0x41.
- Stop bit driven 0, then line held low 40 cycles → RX_FRAME_ERR=1, RX_BREAK=1, RX_DATA=0, state stays WAIT_HIGH. Line released → IDLE, no extra RX_DONE.
- Two back-to-back frames 0x12, 0x34 with RX_READY=0 → second completion gives RX_OVERRUN=1, RX_DATA=0x34. Then RX_READY=1 for one cycle → RX_VALID=0, RX_OVERRUN=0.
- Low glitch of 3 cycles, then a single-sample glitch inside each data bit at counter=H → no RX_DONE from the first; correct byte received from the second.
- rst_n pulsed low during DATA bit 4 → all outputs 0 immediately. A subsequent frame 0x5A is received correctly, with no spurious RX_DONE.
